// File: rtl/io_bus_pkg.sv
// ---------------------------------------------------------------------------
// io_bus_pkg
// Shared definitions for the CPU-side IO bus master and its helpers:
//   - bus width macros (address, data, control)
//   - ctrl bit positions (read, write, size field)
//   - access size encodings
//   - the peripheral page tag (upper 20 address bits)
//   - the master FSM state type
//   - a helper that flags misaligned or illegal requests
// No ports; imported with "import io_bus_pkg::*;".
// ---------------------------------------------------------------------------
`ifndef IO_BUS_WIDTH_ADDR
`define IO_BUS_WIDTH_ADDR 32
`endif
`ifndef IO_BUS_WIDTH_DATA
`define IO_BUS_WIDTH_DATA 32
`endif
`ifndef IO_BUS_WIDTH_CTRL
`define IO_BUS_WIDTH_CTRL 4
`endif

package io_bus_pkg;

  localparam int CTRL_RD       = 0;
  localparam int CTRL_WR       = 1;
  localparam int CTRL_SIZE_LSB = 2;
  localparam int CTRL_SIZE_MSB = 3;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  localparam logic [19:0] PERIPH_PAGE = 20'hFFFFF;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_RESP,
    ST_ERR
  } state_t;

  // Size 11 has no legal meaning, so it is folded into the misaligned case.
  function automatic logic is_misaligned(input logic [1:0] size,
                                         input logic [1:0] lane);
    logic bad;
    case (size)
      SZ_B:    bad = 1'b0;
      SZ_H:    bad = lane[0];
      SZ_W:    bad = (lane != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/io_load_align.sv
// ---------------------------------------------------------------------------
// io_load_align
// Combinational load-data aligner: moves the addressed byte lane down to bit 0
// and sign- or zero-extends it to the full data width.
// Ports:
//   raw       in   IO_BUS_WIDTH_DATA  data as sampled from the bus
//   lane      in   2                  byte offset, addr[1:0]
//   size      in   2                  SZ_B / SZ_H / SZ_W
//   zero_ext  in   1                  1 = zero-extend, 0 = sign-extend
//   result    out  IO_BUS_WIDTH_DATA  right-justified, extended load value
// ---------------------------------------------------------------------------
`ifndef IO_BUS_WIDTH_DATA
`define IO_BUS_WIDTH_DATA 32
`endif

module io_load_align
  import io_bus_pkg::*;
(
  input  logic [`IO_BUS_WIDTH_DATA-1:0] raw,
  input  logic [1:0]                    lane,
  input  logic [1:0]                    size,
  input  logic                          zero_ext,
  output logic [`IO_BUS_WIDTH_DATA-1:0] result
);

  localparam int DW = `IO_BUS_WIDTH_DATA;

  logic [DW-1:0] shifted;
  logic          fill;

  always_comb begin
    shifted = raw >> {lane, 3'b000};
    fill    = 1'b0;
    result  = shifted;
    case (size)
      SZ_B: begin
        fill   = ~zero_ext & shifted[7];
        result = {{(DW-8){fill}}, shifted[7:0]};
      end
      SZ_H: begin
        fill   = ~zero_ext & shifted[15];
        result = {{(DW-16){fill}}, shifted[15:0]};
      end
      default: result = shifted;
    endcase
  end

endmodule

// File: rtl/io_bus_master.sv
// ---------------------------------------------------------------------------
// io_bus_master
// CPU-side master for the IO bus. Accepts one load/store at a time, drives
// BC/addr/ctrl/data for a region-dependent number of wait cycles, aligns and
// extends load data, and returns a one-cycle response.
// Parameters:
//   RAM_WAIT  access cycles for RAM accesses, minus one
//   IO_WAIT   access cycles for peripheral-page accesses, minus one
// Ports:
//   clk           in     1      system clock
//   rst_n         in     1      synchronous active-low reset
//   req_valid     in     1      request present
//   req_ready     out    1      idle; request taken on valid && ready
//   req_we        in     1      1 = store, 0 = load
//   req_size      in     2      00 byte, 01 half, 10 word, 11 illegal
//   req_unsigned  in     1      zero-extend loads
//   req_addr      in     ADDR   byte address
//   req_wdata     in     DATA   store data, right-justified
//   resp_valid    out    1      one-cycle completion pulse
//   resp_rdata    out    DATA   extended load data, 0 for stores/errors
//   resp_err      out    1      misaligned or illegal request
//   BC            out    1      bus cycle active
//   addr          out    ADDR   bus address
//   ctrl          out    CTRL   bit0 read, bit1 write, bits3:2 size
//   data          inout  DATA   driven only during store access cycles
// ---------------------------------------------------------------------------
`ifndef IO_BUS_WIDTH_ADDR
`define IO_BUS_WIDTH_ADDR 32
`endif
`ifndef IO_BUS_WIDTH_DATA
`define IO_BUS_WIDTH_DATA 32
`endif
`ifndef IO_BUS_WIDTH_CTRL
`define IO_BUS_WIDTH_CTRL 4
`endif

module io_bus_master
  import io_bus_pkg::*;
#(
  parameter int RAM_WAIT = 1,
  parameter int IO_WAIT  = 3
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic                          req_we,
  input  logic [1:0]                    req_size,
  input  logic                          req_unsigned,
  input  logic [`IO_BUS_WIDTH_ADDR-1:0] req_addr,
  input  logic [`IO_BUS_WIDTH_DATA-1:0] req_wdata,
  output logic                          resp_valid,
  output logic [`IO_BUS_WIDTH_DATA-1:0] resp_rdata,
  output logic                          resp_err,
  output logic                          BC,
  output logic [`IO_BUS_WIDTH_ADDR-1:0] addr,
  output logic [`IO_BUS_WIDTH_CTRL-1:0] ctrl,
  inout  wire  [`IO_BUS_WIDTH_DATA-1:0] data
);

  localparam int AW       = `IO_BUS_WIDTH_ADDR;
  localparam int DW       = `IO_BUS_WIDTH_DATA;
  localparam int CW       = `IO_BUS_WIDTH_CTRL;
  localparam int MAX_WAIT = (RAM_WAIT > IO_WAIT) ? RAM_WAIT : IO_WAIT;
  // Keep the counter at least one bit wide even when both waits are zero.
  localparam int WCNT_W   = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;

  state_t            state_q, state_d;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;
  logic              bc_q, bc_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic [CW-1:0]     ctrl_q, ctrl_d;
  logic              oe_q, oe_d;
  logic [DW-1:0]     bus_wdata_q, bus_wdata_d;
  logic [1:0]        size_q, size_d;
  logic              zext_q, zext_d;
  logic              resp_valid_q, resp_valid_d;
  logic              resp_err_q, resp_err_d;
  logic [DW-1:0]     resp_rdata_q, resp_rdata_d;

  logic [DW-1:0]     store_masked;
  logic [DW-1:0]     store_lane;
  logic [DW-1:0]     load_data;
  logic              is_periph;

  // Ready is forced low while reset is asserted so a request arriving in the
  // reset cycle is never considered accepted.
  assign req_ready = rst_n && (state_q == ST_IDLE);

  assign is_periph = (req_addr[AW-1:AW-20] == PERIPH_PAGE);

  // Store data is trimmed to its size first so that bits outside the active
  // byte lanes are driven as zero, then moved into position.
  always_comb begin
    store_masked = '0;
    case (req_size)
      SZ_B:    store_masked[7:0]  = req_wdata[7:0];
      SZ_H:    store_masked[15:0] = req_wdata[15:0];
      default: store_masked       = req_wdata;
    endcase
    store_lane = store_masked << {req_addr[1:0], 3'b000};
  end

  // The latched address and size are only meaningful during ACCESS, which is
  // exactly when the aligner output is consumed.
  io_load_align u_load_align (
    .raw      (data),
    .lane     (addr_q[1:0]),
    .size     (size_q),
    .zero_ext (zext_q),
    .result   (load_data)
  );

  // Next-state logic. All bus-facing outputs are computed one cycle ahead
  // here and then registered, so they only ever change on a clk edge.
  always_comb begin
    state_d      = state_q;
    wcnt_d       = wcnt_q;
    bc_d         = bc_q;
    addr_d       = addr_q;
    ctrl_d       = ctrl_q;
    oe_d         = oe_q;
    bus_wdata_d  = bus_wdata_q;
    size_d       = size_q;
    zext_d       = zext_q;
    resp_valid_d = 1'b0;
    resp_err_d   = 1'b0;
    resp_rdata_d = '0;

    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          size_d = req_size;
          zext_d = req_unsigned;
          if (is_misaligned(req_size, req_addr[1:0])) begin
            state_d      = ST_ERR;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
          end else begin
            state_d     = ST_ACCESS;
            wcnt_d      = is_periph ? WCNT_W'(IO_WAIT) : WCNT_W'(RAM_WAIT);
            bc_d        = 1'b1;
            addr_d      = req_addr;
            ctrl_d      = '0;
            ctrl_d[CTRL_RD] = ~req_we;
            ctrl_d[CTRL_WR] = req_we;
            ctrl_d[CTRL_SIZE_MSB:CTRL_SIZE_LSB] = req_size;
            oe_d        = req_we;
            bus_wdata_d = store_lane;
          end
        end
      end

      ST_ACCESS: begin
        if (wcnt_q == '0) begin
          state_d      = ST_RESP;
          bc_d         = 1'b0;
          addr_d       = '0;
          ctrl_d       = '0;
          oe_d         = 1'b0;
          bus_wdata_d  = '0;
          resp_valid_d = 1'b1;
          resp_rdata_d = ctrl_q[CTRL_RD] ? load_data : '0;
        end else begin
          wcnt_d = wcnt_q - 1'b1;
        end
      end

      ST_RESP: state_d = ST_IDLE;

      ST_ERR:  state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers. Reset aborts any in-flight access without a
  // response and releases the data bus.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      wcnt_q       <= '0;
      bc_q         <= 1'b0;
      addr_q       <= '0;
      ctrl_q       <= '0;
      oe_q         <= 1'b0;
      bus_wdata_q  <= '0;
      size_q       <= SZ_B;
      zext_q       <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      wcnt_q       <= wcnt_d;
      bc_q         <= bc_d;
      addr_q       <= addr_d;
      ctrl_q       <= ctrl_d;
      oe_q         <= oe_d;
      bus_wdata_q  <= bus_wdata_d;
      size_q       <= size_d;
      zext_q       <= zext_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end

  assign BC         = bc_q;
  assign addr       = addr_q;
  assign ctrl       = ctrl_q;
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_rdata = resp_rdata_q;

  assign data = oe_q ? bus_wdata_q : {DW{1'bz}};

endmodule

// File: tb/tb_io_bus_master.sv
// ---------------------------------------------------------------------------
// tb_io_bus_master
// Self-checking bench for io_bus_master (RAM_WAIT=1, IO_WAIT=3). Responses
// are checked by a scoreboard queue filled when each request is driven;
// timing and bus behaviour are checked inline in each scenario task.
// The bench acts as the bus slave: it drives load data, or a zero keeper
// whenever the master is expected to have released the bus.
// ---------------------------------------------------------------------------
`ifndef IO_BUS_WIDTH_ADDR
`define IO_BUS_WIDTH_ADDR 32
`endif
`ifndef IO_BUS_WIDTH_DATA
`define IO_BUS_WIDTH_DATA 32
`endif
`ifndef IO_BUS_WIDTH_CTRL
`define IO_BUS_WIDTH_CTRL 4
`endif

module tb_io_bus_master;
  import io_bus_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        bc;
  logic [31:0] bus_addr;
  logic [3:0]  bus_ctrl;
  wire  [31:0] data_bus;

  logic        tb_oe;
  logic [31:0] tb_data;
  assign data_bus = tb_oe ? tb_data : 32'hzzzz_zzzz;

  logic [31:0] ref_raw;
  logic [1:0]  ref_lane;
  logic [1:0]  ref_size;
  logic        ref_zext;
  logic [31:0] ref_out;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t sb_q[$];
  exp_t sb_head;
  int   compared;
  int   mismatched;

  io_bus_master #(
    .RAM_WAIT (1),
    .IO_WAIT  (3)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err),
    .BC           (bc),
    .addr         (bus_addr),
    .ctrl         (bus_ctrl),
    .data         (data_bus)
  );

  io_load_align u_ref (
    .raw      (ref_raw),
    .lane     (ref_lane),
    .size     (ref_size),
    .zero_ext (ref_zext),
    .result   (ref_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Independent load model: picks the lane with a part-select.
  function automatic logic [31:0] exp_load(input logic [31:0] raw, input logic [1:0] lo,
                                           input logic [1:0] size, input logic zext);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (size)
      2'b00: begin
        b = raw[8*lo +: 8];
        r = zext ? {24'h0, b} : {{24{b[7]}}, b};
      end
      2'b01: begin
        h = lo[1] ? raw[31:16] : raw[15:0];
        r = zext ? {16'h0, h} : {{16{h[15]}}, h};
      end
      default: r = raw;
    endcase
    return r;
  endfunction

  // Scoreboard: every response pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (resp_valid === 1'b1) begin
      compared++;
      if (sb_q.size() == 0) begin
        mismatched++;
        $display("[TB] FAIL unexpected_resp: got rdata=%h err=%b, required no response", resp_rdata, resp_err);
      end else begin
        sb_head = sb_q.pop_front();
        if (resp_rdata !== sb_head.rdata || resp_err !== sb_head.err) begin
          mismatched++;
          $display("[TB] FAIL resp_payload: got rdata=%h err=%b, required rdata=%h err=%b",
                   resp_rdata, resp_err, sb_head.rdata, sb_head.err);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation time budget exhausted");
    $fatal(1, "[TB] timeout");
  end

  task automatic drive_req(input logic we, input logic [1:0] size, input logic uns,
                           input logic [31:0] a, input logic [31:0] wd);
    req_valid    = 1'b1;
    req_we       = we;
    req_size     = size;
    req_unsigned = uns;
    req_addr     = a;
    req_wdata    = wd;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tb_oe = 1'b1;
    tb_data = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    compared++;
    if ({bc, bus_ctrl, bus_addr} !== 37'h0) begin
      mismatched++;
      $display("[TB] FAIL reset_bus: got BC=%b ctrl=%h addr=%h, required all zero", bc, bus_ctrl, bus_addr);
    end
    compared++;
    if ({resp_valid, resp_err, resp_rdata} !== 34'h0) begin
      mismatched++;
      $display("[TB] FAIL reset_resp: got valid=%b err=%b rdata=%h, required all zero", resp_valid, resp_err, resp_rdata);
    end
    compared++;
    if (req_ready !== 1'b0 || data_bus !== 32'h0) begin
      mismatched++;
      $display("[TB] FAIL reset_ready_bus: got ready=%b data=%h, required ready=0 data=0", req_ready, data_bus);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    compared++;
    if (req_ready !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL reset_release_ready: got %b, required 1", req_ready);
    end
  endtask

  task automatic test_word_load();
    int bc_cnt;
    int resp_at;
    bc_cnt  = 0;
    resp_at = 0;
    tb_oe   = 1'b1;
    tb_data = 32'hDEADBEEF;
    @(posedge clk); #1;
    drive_req(1'b0, SZ_W, 1'b0, 32'h0000_0100, 32'h0);
    sb_q.push_back({32'hDEADBEEF, 1'b0});
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (bc === 1'b1) begin
        bc_cnt++;
        compared++;
        if (bus_ctrl !== 4'b1001 || bus_addr !== 32'h0000_0100) begin
          mismatched++;
          $display("[TB] FAIL word_load_bus: got ctrl=%b addr=%h, required ctrl=1001 addr=00000100", bus_ctrl, bus_addr);
        end
      end
      if (resp_valid === 1'b1 && resp_at == 0) resp_at = c;
    end
    compared++;
    if (bc_cnt != 2 || resp_at != 3) begin
      mismatched++;
      $display("[TB] FAIL word_load_timing: got BC cycles=%0d resp cycle=%0d, required 2 and 3", bc_cnt, resp_at);
    end
  endtask

  task automatic test_byte_load();
    int resp_at;
    tb_oe   = 1'b1;
    tb_data = 32'h80FFFFFF;
    for (int u = 0; u < 2; u++) begin
      resp_at = 0;
      @(posedge clk); #1;
      drive_req(1'b0, SZ_B, u[0], 32'h0000_0103, 32'h0);
      sb_q.push_back({(u == 0) ? 32'hFFFFFF80 : 32'h00000080, 1'b0});
      @(posedge clk); #1;
      req_valid = 1'b0;
      for (int c = 1; c <= 5; c++) begin
        @(negedge clk);
        if (resp_valid === 1'b1 && resp_at == 0) resp_at = c;
      end
      compared++;
      if (resp_at != 3) begin
        mismatched++;
        $display("[TB] FAIL byte_load_latency: unsigned=%0d got resp cycle %0d, required 3", u, resp_at);
      end
    end
  endtask

  task automatic test_half_store_io();
    int resp_at;
    resp_at = 0;
    tb_oe   = 1'b1;
    tb_data = 32'h0;
    @(posedge clk); #1;
    drive_req(1'b1, SZ_H, 1'b0, 32'hFFFFF062, 32'h0000_1234);
    sb_q.push_back({32'h0, 1'b0});
    @(negedge clk);
    compared++;
    if (data_bus !== 32'h0 || bc !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL half_store_pre: got data=%h BC=%b, required released bus and BC=0", data_bus, bc);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    tb_oe     = 1'b0;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      compared++;
      if (c <= 4) begin
        if (bc !== 1'b1 || bus_ctrl !== 4'b0110 || bus_addr !== 32'hFFFFF062 || data_bus !== 32'h12340000) begin
          mismatched++;
          $display("[TB] FAIL half_store_access c%0d: got BC=%b ctrl=%b addr=%h data=%h, required 1 0110 FFFFF062 12340000",
                   c, bc, bus_ctrl, bus_addr, data_bus);
        end
      end else begin
        if (bc !== 1'b0 || bus_ctrl !== 4'b0 || data_bus !== 32'h0) begin
          mismatched++;
          $display("[TB] FAIL half_store_post c%0d: got BC=%b ctrl=%b data=%h, required 0 0000 released", c, bc, bus_ctrl, data_bus);
        end
      end
      if (resp_valid === 1'b1 && resp_at == 0) resp_at = c;
      @(posedge clk); #1;
      if (c == 4) tb_oe = 1'b1;
    end
    compared++;
    if (resp_at != 5) begin
      mismatched++;
      $display("[TB] FAIL half_store_latency: got resp cycle %0d, required 5", resp_at);
    end
  endtask

  task automatic test_misaligned();
    logic bc_seen;
    bc_seen = 1'b0;
    @(posedge clk); #1;
    drive_req(1'b0, SZ_W, 1'b0, 32'h0000_0102, 32'h0);
    sb_q.push_back({32'h0, 1'b1});
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      if (bc === 1'b1) bc_seen = 1'b1;
      if (c == 1) begin
        compared++;
        if (resp_valid !== 1'b1 || resp_err !== 1'b1 || req_ready !== 1'b0) begin
          mismatched++;
          $display("[TB] FAIL misaligned_e1: got valid=%b err=%b ready=%b, required 1 1 0", resp_valid, resp_err, req_ready);
        end
      end
      if (c == 2) begin
        compared++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
          mismatched++;
          $display("[TB] FAIL misaligned_e2: got valid=%b ready=%b, required 0 1", resp_valid, req_ready);
        end
      end
    end
    compared++;
    if (bc_seen !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL misaligned_bc: got BC asserted, required no bus cycle");
    end
  endtask

  task automatic test_back_to_back();
    int   ready_at;
    int   bc_cnt;
    int   resp1;
    int   resp2;
    logic gap_bc;
    ready_at = 0;
    bc_cnt   = 0;
    resp1    = 0;
    resp2    = 0;
    gap_bc   = 1'b1;
    tb_oe    = 1'b0;
    @(posedge clk); #1;
    drive_req(1'b1, SZ_W, 1'b0, 32'h0000_0200, 32'hCAFEF00D);
    sb_q.push_back({32'h0, 1'b0});
    sb_q.push_back({32'h0, 1'b0});
    @(negedge clk);
    compared++;
    if (req_ready !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL b2b_first_ready: got %b, required 1", req_ready);
    end
    @(posedge clk); #1;
    drive_req(1'b1, SZ_B, 1'b0, 32'h0000_0205, 32'h0000_0077);
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      if (req_valid && req_ready === 1'b1 && ready_at == 0) begin
        ready_at = c;
        gap_bc   = bc;
      end
      if (bc === 1'b1) bc_cnt++;
      if (resp_valid === 1'b1) begin
        if (resp1 == 0) resp1 = c;
        else if (resp2 == 0) resp2 = c;
      end
      @(posedge clk); #1;
      if (c == ready_at) req_valid = 1'b0;
    end
    compared++;
    if (ready_at != 4 || gap_bc !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL b2b_accept: got second accept cycle %0d BC=%b, required 4 BC=0", ready_at, gap_bc);
    end
    compared++;
    if (bc_cnt != 4 || resp1 != 3 || resp2 != 7) begin
      mismatched++;
      $display("[TB] FAIL b2b_timing: got BC cycles=%0d resp=%0d,%0d, required 4 and 3,7", bc_cnt, resp1, resp2);
    end
    tb_oe   = 1'b1;
    tb_data = 32'h0;
  endtask

  task automatic test_reset_mid_access();
    int resp_at;
    resp_at = 0;
    tb_oe   = 1'b1;
    tb_data = 32'h0BADF00D;
    @(posedge clk); #1;
    drive_req(1'b0, SZ_W, 1'b0, 32'hFFFFF010, 32'h0);
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    compared++;
    if (bc !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL rst_mid_first_access: got BC=%b, required 1", bc);
    end
    @(posedge clk); #1;
    rst_n = 1'b0;
    drive_req(1'b0, SZ_W, 1'b0, 32'h0000_0300, 32'h0);
    @(negedge clk);
    compared++;
    if (req_ready !== 1'b0 || bc !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL rst_mid_during: got ready=%b BC=%b, required ready=0 BC=1", req_ready, bc);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    sb_q.push_back({32'h0BADF00D, 1'b0});
    @(negedge clk);
    compared++;
    if (bc !== 1'b0 || bus_ctrl !== 4'b0 || bus_addr !== 32'h0 || resp_valid !== 1'b0 || data_bus !== 32'h0BADF00D) begin
      mismatched++;
      $display("[TB] FAIL rst_mid_after: got BC=%b ctrl=%b addr=%h valid=%b data=%h, required idle bus", bc, bus_ctrl, bus_addr, resp_valid, data_bus);
    end
    compared++;
    if (req_ready !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL rst_mid_ready: got %b, required 1", req_ready);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int c = 4; c <= 9; c++) begin
      @(negedge clk);
      if (resp_valid === 1'b1 && resp_at == 0) resp_at = c;
    end
    compared++;
    if (resp_at != 6) begin
      mismatched++;
      $display("[TB] FAIL rst_mid_new_req: got resp cycle %0d, required 6", resp_at);
    end
  endtask

  task automatic test_random();
    logic        we;
    logic [1:0]  size;
    logic [1:0]  lo;
    logic        zext;
    logic        periph;
    logic        bad;
    logic [31:0] a;
    logic [31:0] raw;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    int          exp_lat;
    int          resp_at;
    for (int i = 0; i < 12; i++) begin
      we     = 1'($urandom_range(0, 1));
      size   = 2'($urandom_range(0, 3));
      lo     = 2'($urandom_range(0, 3));
      zext   = 1'($urandom_range(0, 1));
      periph = 1'($urandom_range(0, 1));
      raw    = $urandom;
      wd     = $urandom;
      a      = periph ? {20'hFFFFF, 12'($urandom)} : {20'h00010, 12'($urandom)};
      a[1:0] = lo;
      bad    = (size == 2'b11) || (size == 2'b01 && lo[0]) || (size == 2'b10 && lo != 2'b00);
      exp_rd = (bad || we) ? 32'h0 : exp_load(raw, lo, size, zext);
      exp_lat = bad ? 1 : (periph ? 5 : 3);
      tb_oe   = ~we;
      tb_data = raw;
      resp_at = 0;
      @(posedge clk); #1;
      drive_req(we, size, zext, a, wd);
      sb_q.push_back({exp_rd, bad});
      @(posedge clk); #1;
      req_valid = 1'b0;
      for (int c = 1; c <= 8; c++) begin
        @(negedge clk);
        if (resp_valid === 1'b1 && resp_at == 0) resp_at = c;
      end
      compared++;
      if (resp_at != exp_lat) begin
        mismatched++;
        $display("[TB] FAIL rand_latency #%0d: got resp cycle %0d, required %0d", i, resp_at, exp_lat);
      end
      if (!we && !bad) begin
        ref_raw  = raw;
        ref_lane = lo;
        ref_size = size;
        ref_zext = zext;
        #1;
        compared++;
        if (ref_out !== exp_rd) begin
          mismatched++;
          $display("[TB] FAIL rand_align #%0d: got %h, required %h", i, ref_out, exp_rd);
        end
      end
    end
    tb_oe   = 1'b1;
    tb_data = 32'h0;
  endtask

  initial begin
    rst_n        = 1'b0;
    req_valid    = 1'b0;
    req_we       = 1'b0;
    req_size     = 2'b00;
    req_unsigned = 1'b0;
    req_addr     = 32'h0;
    req_wdata    = 32'h0;
    tb_oe        = 1'b1;
    tb_data      = 32'h0;
    ref_raw      = 32'h0;
    ref_lane     = 2'b00;
    ref_size     = 2'b00;
    ref_zext     = 1'b0;
    compared     = 0;
    mismatched   = 0;

    test_reset();
    test_word_load();
    test_byte_load();
    test_half_store_io();
    test_misaligned();
    test_back_to_back();
    test_reset_mid_access();
    test_random();

    repeat (3) @(posedge clk);
    @(negedge clk);
    compared++;
    if (sb_q.size() != 0) begin
      mismatched++;
      $display("[TB] FAIL sb_drain: got %0d responses outstanding, required 0", sb_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/io_bus_master.md
# io_bus_master

CPU-side master for the IO bus. Takes one load/store request at a time from the memory-access stage and drives the bus address, control, data and BC lines for a fixed number of wait cycles. Region decode selects the wait count: RAM, or the peripheral page at 0xFFFFF000–0xFFFFFFFF. It handles byte lanes and sign extension, and returns a one-cycle response. It sits directly upstream of the bus decoder/interface fabric.

## Interface
Parameters:
- RAM_WAIT, 1: access cycles for RAM-region accesses, minus one.
- IO_WAIT, 3: access cycles for peripheral-page accesses, minus one. Covers slow device-clock interfaces.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, synchronous, active-low
- req_valid  in  1  request present
- req_ready  out  1  master idle; request accepted when valid && ready
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 half, 10 word; 11 is illegal and treated as misaligned
- req_unsigned  in  1  zero-extend loads
- req_addr  in  `IO_BUS_WIDTH_ADDR  byte address
- req_wdata  in  `IO_BUS_WIDTH_DATA  store data, right-justified
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  `IO_BUS_WIDTH_DATA  extended load data; 0 for stores
- resp_err  out  1  misaligned or illegal request; qualified by resp_valid
- BC  out  1  bus cycle active
- addr  out  `IO_BUS_WIDTH_ADDR  bus address
- ctrl  out  `IO_BUS_WIDTH_CTRL  bit0 read, bit1 write, bits3:2 size
- data  inout  `IO_BUS_WIDTH_DATA  driven only during store access cycles, else high-Z

## Operation
The FSM has four states: IDLE, ACCESS, RESP, ERR.
- **IDLE**
  - req_ready=1.
  - On accept, latch the request.
  - Misaligned requests go to ERR: half with addr[0]≠0, word with addr[1:0]≠0, or size 11. They cause no bus activity.
  - All other requests go to ACCESS with wcnt = (addr[31:12]==20'hFFFFF) ? IO_WAIT : RAM_WAIT.
- **ACCESS**
  - BC=1, addr=latched address, ctrl={size, we, ~we}.
  - Stores drive data = wdata << (8·addr[1:0]); bits outside the lane are 0.
  - wcnt decrements each cycle.
  - At wcnt==0: for a load, sample data, shift right by 8·addr[1:0], then sign- or zero-extend per size and req_unsigned into resp_rdata. Then go to RESP.
- **RESP**: resp_valid=1, resp_err=0, then IDLE.
- **ERR**: resp_valid=1, resp_err=1, resp_rdata=0, then IDLE.
- Idle outputs: BC=0, ctrl=0, addr=0, data high-Z.
- The bus outputs (BC, addr, ctrl, data enable, store data) are registered and glitch-free; they change only on clk edges.
- Only one outstanding request. req_ready is 0 in every state except IDLE.

## Timing
- Accept at edge E.
- ACCESS cycles run from E+1 through E+1+W, where W is the selected wait count.
- The load sample is taken on the edge ending cycle E+1+W.
- resp_valid is high during cycle E+2+W.
- IDLE resumes in cycle E+3+W, so a back-to-back request is accepted at the earliest in that cycle.
- Error path: resp_valid with resp_err high during cycle E+1; IDLE in E+2.
- Reset (rst_n low at an edge), from any state:
  - State goes to IDLE, BC=0, ctrl=0, addr=0, data high-Z.
  - resp_valid=0, resp_rdata=0, resp_err=0.
  - req_ready=0 combinationally while rst_n is low.
  - An in-flight access is aborted with no response.
- A request arriving in the same cycle as reset is dropped.
- wcnt width is $clog2(max(RAM_WAIT, IO_WAIT)+1). W=0 is legal: a single ACCESS cycle.

## Structure
- Shared package io_bus_pkg holds:
  - ctrl bit positions (CTRL_RD=0, CTRL_WR=1, CTRL_SIZE=3:2)
  - size encodings SZ_B/SZ_H/SZ_W
  - PERIPH_PAGE=20'hFFFFF
  - FSM state typedef
- Sub-module io_load_align is combinational: lane shift plus sign/zero extension, keyed on addr[1:0], size and unsigned. It is reused for load-data checking in the bench.
- The tri-state driver is a single continuous assign on an output-enable register.

## Test plan
- **Word load, RAM:** req_addr=0x00000100, RAM_WAIT=1, bus model returns 0xDEADBEEF.
  - BC high for exactly 2 cycles, ctrl=4'b1001.
  - resp_valid at E+3, resp_rdata=0xDEADBEEF, resp_err=0.
- **Signed byte load:** addr=0x00000103, bus returns 0x80FFFFFF.
  - resp_rdata=0xFFFFFF80.
  - The same access with req_unsigned=1 gives 0x00000080.
- **Half store, peripheral page:** addr=0xFFFFF062, wdata=0x1234, IO_WAIT=3.
  - BC high 4 cycles, ctrl=4'b0110, data=0x12340000 throughout.
  - data is high-Z before the first and after the last ACCESS cycle.
  - resp_valid at E+5.
- **Misaligned word load:** addr=0x00000102.
  - No BC assertion; resp_valid and resp_err at E+1; req_ready again at E+2.
- **Back-to-back:** req_valid held high with two stores.
  - Second accept occurs exactly in the first cycle after RESP.
  - BC deasserted for at least that one cycle between the two accesses.
- **Reset mid-access:** rst_n low during the 2nd ACCESS cycle of an IO load.
  - Next cycle BC=0, ctrl=0, data high-Z, and no resp_valid ever appears for that load.
  - A new request is accepted the cycle after rst_n returns high.
